// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
//   Groups the multiplexed 7-segment bus and the decoder's result signals.
//   master : the display driver side (drives seg_n/an_n, observes results)
//   slave  : the scan decoder (samples seg_n/an_n, drives results)
//
//   seg_n       7   segment lines, active-low, [0]=a .. [6]=g
//   an_n        4   digit anodes, active-low, [0]=ones .. [3]=thousands
//   value       14  last published decimal value
//   value_valid 1   one-cycle pulse on every publish
//   err_flag    1   last published frame contained an E digit
//   frame_bad   1   one-cycle pulse for a frame with an undecodable digit
//   active      1   a digit has been captured recently
interface seg7_scan_decoder_if;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [13:0] value;
    logic        value_valid;
    logic        err_flag;
    logic        frame_bad;
    logic        active;

    modport master (
        output seg_n, an_n,
        input  value, value_valid, err_flag, frame_bad, active
    );

    modport slave (
        input  seg_n, an_n,
        output value, value_valid, err_flag, frame_bad, active
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Samples a multiplexed active-low 7-segment display bus, decodes each digit,
//   reassembles 4-digit frames and publishes the binary value once the same
//   frame has been seen MATCH_FRAMES times in a row.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_decoder_if.slave (display bus in, results out)
//
//   Digit capture FSM:
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for exactly one anode low
//   SETTLE | counting consecutive identical (an_n, seg_n) samples
//   HOLD   | digit captured, waiting for the anode to change
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int MATCH_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] CODE_E     = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;
    localparam logic [3:0] CODE_BAD   = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    logic [6:0]       seg_m, seg_s;
    logic [3:0]       an_m, an_s;

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [3:0]       cap_an;
    logic [6:0]       cap_seg;

    logic [3:0][3:0]  slots;
    logic [3:0][3:0]  cand;
    logic [3:0][3:0]  last_pub;
    logic [3:0]       mask;
    logic [2:0]       match_cnt;
    logic             published;
    logic             pub_pend;
    logic [TW-1:0]    to_left;

    logic [13:0]      value_r;
    logic             value_valid_r;
    logic             err_flag_r;
    logic             frame_bad_r;
    logic             active_r;

    logic             is_onehot;
    logic             same_sample;
    logic             cap_now;
    logic [1:0]       cap_idx;
    logic [3:0]       cap_code;
    logic             frame_full;
    logic             any_bad;
    logic             cand_has_e;
    logic [2:0]       match_next;
    logic             timeout_hit;
    logic [13:0]      bin_value;

    function automatic logic [3:0] decode_seg(input logic [6:0] seg_n_v);
        logic [6:0] pat;
        pat = ~seg_n_v;
        case (pat)
            7'h3F:   return 4'd0;
            7'h06:   return 4'd1;
            7'h5B:   return 4'd2;
            7'h4F:   return 4'd3;
            7'h66:   return 4'd4;
            7'h6D:   return 4'd5;
            7'h7D:   return 4'd6;
            7'h07:   return 4'd7;
            7'h7F:   return 4'd8;
            7'h6F:   return 4'd9;
            7'h79:   return CODE_E;
            7'h00:   return CODE_BLANK;
            default: return CODE_BAD;
        endcase
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] an_n_v);
        case (an_n_v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Blank and E contribute nothing to the binary value.
    function automatic logic [13:0] digit_val(input logic [3:0] code);
        return (code < 4'd10) ? {10'd0, code} : 14'd0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '0;
            seg_s <= '0;
            an_m  <= '0;
            an_s  <= '0;
        end else begin
            seg_m <= bus.seg_n;
            seg_s <= seg_m;
            an_m  <= bus.an_n;
            an_s  <= an_m;
        end
    end

    assign is_onehot   = $onehot(~an_s);
    assign same_sample = (an_s == cap_an) && (seg_s == cap_seg);
    assign cap_idx     = anode_index(an_s);
    assign cap_code    = decode_seg(seg_s);

    // With SETTLE_CYCLES=1 the first one-hot sample is already enough.
    always_comb begin
        cap_now = 1'b0;
        case (state)
            IDLE:    cap_now = is_onehot && (SETTLE_CYCLES == 1);
            SETTLE:  cap_now = same_sample && ((settle_cnt + 4'd1) == 4'(SETTLE_CYCLES));
            default: cap_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cap_an     <= '0;
            cap_seg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_onehot) begin
                        cap_an     <= an_s;
                        cap_seg    <= seg_s;
                        settle_cnt <= 4'd1;
                        state      <= cap_now ? HOLD : SETTLE;
                    end
                end
                SETTLE: begin
                    if (same_sample) begin
                        settle_cnt <= settle_cnt + 4'd1;
                        if (cap_now) state <= HOLD;
                    end else if (is_onehot) begin
                        cap_an     <= an_s;
                        cap_seg    <= seg_s;
                        settle_cnt <= 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (an_s != cap_an) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_full  = (mask == 4'hF);
    assign timeout_hit = !cap_now && (to_left == TW'(1));

    always_comb begin
        any_bad    = 1'b0;
        cand_has_e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (slots[i] == CODE_BAD) any_bad = 1'b1;
            if (cand[i] == CODE_E)    cand_has_e = 1'b1;
        end
    end

    always_comb begin
        match_next = 3'd1;
        if (slots == cand) begin
            match_next = (match_cnt == 3'(MATCH_FRAMES)) ? match_cnt : match_cnt + 3'd1;
        end
    end

    assign bin_value = digit_val(cand[3]) * 14'd1000 + digit_val(cand[2]) * 14'd100
                     + digit_val(cand[1]) * 14'd10   + digit_val(cand[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots         <= '0;
            cand          <= '0;
            last_pub      <= '0;
            mask          <= '0;
            match_cnt     <= '0;
            published     <= 1'b0;
            pub_pend      <= 1'b0;
            to_left       <= TW'(TIMEOUT_CYCLES);
            value_r       <= '0;
            value_valid_r <= 1'b0;
            err_flag_r    <= 1'b0;
            frame_bad_r   <= 1'b0;
            active_r      <= 1'b0;
        end else begin
            value_valid_r <= 1'b0;
            frame_bad_r   <= 1'b0;
            pub_pend      <= 1'b0;

            // Inactivity timer: reloads on capture, counts down otherwise.
            if (cap_now) begin
                slots[cap_idx] <= cap_code;
                to_left        <= TW'(TIMEOUT_CYCLES);
                active_r       <= 1'b1;
            end else if (to_left != '0) begin
                to_left <= to_left - TW'(1);
            end

            if (timeout_hit) begin
                active_r  <= 1'b0;
                mask      <= '0;
                match_cnt <= '0;
                published <= 1'b0;
            end else begin
                mask <= (frame_full ? 4'b0000 : mask) | (cap_now ? ~an_s : 4'b0000);
                if (frame_full) begin
                    if (any_bad) begin
                        frame_bad_r <= 1'b1;
                        match_cnt   <= '0;
                    end else begin
                        cand      <= slots;
                        match_cnt <= match_next;
                        if ((match_next == 3'(MATCH_FRAMES)) && (!published || (slots != last_pub))) begin
                            pub_pend  <= 1'b1;
                            published <= 1'b1;
                            last_pub  <= slots;
                        end
                    end
                end
            end

            // Conversion stage: cand already holds the frame being published.
            if (pub_pend) begin
                value_valid_r <= 1'b1;
                if (cand_has_e) begin
                    err_flag_r <= 1'b1;
                end else begin
                    err_flag_r <= 1'b0;
                    value_r    <= bin_value;
                end
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.value_valid = value_valid_r;
    assign bus.err_flag    = err_flag_r;
    assign bus.frame_bad   = frame_bad_r;
    assign bus.active      = active_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;
    localparam int MATCH  = 2;
    localparam int TMO    = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .MATCH_FRAMES  (MATCH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef int frame_t [4];
    typedef struct {
        int value;
        int err;
    } pub_t;

    int     checks = 0;
    int     errors = 0;
    pub_t   exp_q[$];
    int     bad_q[$];

    // Frame-level reference model. Digit codes: 0..9, 10=E, 11=blank, >=12 invalid.
    frame_t m_cand, m_last;
    int     m_match, m_pub, m_value, m_err;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit same_frame(input frame_t a, input frame_t b);
        for (int i = 0; i < 4; i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_value = 0;
        m_err   = 0;
        m_match = 0;
        m_pub   = 0;
        for (int i = 0; i < 4; i++) begin
            m_cand[i] = -1;
            m_last[i] = -1;
        end
    endfunction

    function automatic void model_frame(input frame_t f);
        int w[4] = '{1, 10, 100, 1000};
        int v = 0;
        bit bad = 1'b0;
        bit has_e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f[i] >= 12) bad = 1'b1;
            if (f[i] == 10) has_e = 1'b1;
            if (f[i] < 10) v += f[i] * w[i];
        end
        if (bad) begin
            bad_q.push_back(1);
            m_match = 0;
            return;
        end
        if (same_frame(f, m_cand)) begin
            if (m_match < MATCH) m_match++;
        end else begin
            m_cand  = f;
            m_match = 1;
        end
        if (m_match == MATCH && (m_pub == 0 || !same_frame(f, m_last))) begin
            m_pub  = 1;
            m_last = f;
            if (has_e) m_err = 1;
            else begin
                m_err   = 0;
                m_value = v;
            end
            exp_q.push_back('{value: m_value, err: m_err});
        end
    endfunction

    function automatic logic [6:0] pat(input int code);
        logic [6:0] bad_list[4] = '{7'h01, 7'h7E, 7'h40, 7'h3E};
        case (code)
            0:  return 7'h3F;
            1:  return 7'h06;
            2:  return 7'h5B;
            3:  return 7'h4F;
            4:  return 7'h66;
            5:  return 7'h6D;
            6:  return 7'h7D;
            7:  return 7'h07;
            8:  return 7'h7F;
            9:  return 7'h6F;
            10: return 7'h79;
            11: return 7'h00;
            12: return 7'h12;
            default: return bad_list[$urandom_range(0, 3)];
        endcase
    endfunction

    task automatic drive(input logic [3:0] an, input logic [6:0] p_hi);
        @(negedge clk);
        bus.an_n  = an;
        bus.seg_n = ~p_hi;
    endtask

    // mode 0: clean 8 cycles; 1: 2-cycle segment glitch first; 2: 2 non-one-hot anode cycles first
    task automatic scan_digit(input int idx, input int code, input int mode);
        logic [6:0] p;
        logic [3:0] an;
        p  = pat(code);
        an = ~(4'b0001 << idx);
        if (mode == 2) begin
            repeat (2) drive(($urandom_range(0, 1) == 1) ? 4'b0000 : 4'b1100, 7'($urandom));
        end
        if (mode == 1) begin
            repeat (2) drive(an, 7'($urandom));
            repeat (6) drive(an, p);
        end else begin
            repeat (8) drive(an, p);
        end
    endtask

    task automatic scan_frame(input frame_t f, input bit glitch);
        model_frame(f);
        for (int i = 0; i < 4; i++) scan_digit(i, f[i], glitch ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic drain(input string name);
        drive(4'hF, 7'h00);
        repeat (12) @(negedge clk);
        chk({name, "_pending"}, exp_q.size() + bad_q.size(), 0);
    endtask

    always @(negedge clk) begin
        pub_t e;
        if (rst_n) begin
            if (bus.value_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_publish value=%0d err_flag=%0d expected no pulse at %0t",
                             bus.value, bus.err_flag, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("publish_value", int'(bus.value), e.value);
                    chk("publish_err_flag", int'(bus.err_flag), e.err);
                end
            end
            if (bus.frame_bad) begin
                checks++;
                if (bad_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame_bad got=1 expected=0 at %0t", $time);
                end else begin
                    void'(bad_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_value"}, int'(bus.value), 0);
        chk({name, "_value_valid"}, int'(bus.value_valid), 0);
        chk({name, "_err_flag"}, int'(bus.err_flag), 0);
        chk({name, "_frame_bad"}, int'(bus.frame_bad), 0);
        chk({name, "_active"}, int'(bus.active), 0);
    endtask

    initial begin
        frame_t f;
        rst_n     = 1'b0;
        bus.an_n  = 4'hF;
        bus.seg_n = 7'h7F;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 0250 three times: one publish only
        f = '{0, 5, 2, 0};
        repeat (3) scan_frame(f, 1'b0);
        drain("t_0250");
        chk("t_0250_value", int'(bus.value), 250);
        chk("t_0250_err", int'(bus.err_flag), 0);
        chk("t_0250_active", int'(bus.active), 1);

        f = '{9, 9, 9, 9};
        repeat (2) scan_frame(f, 1'b0);
        drain("t_9999");
        chk("t_9999_value", int'(bus.value), 9999);
        f = '{1, 0, 0, 0};
        repeat (2) scan_frame(f, 1'b0);
        drain("t_0001");
        chk("t_0001_value", int'(bus.value), 1);

        // E in thousands, others blank: error frame, value held
        f = '{11, 11, 11, 10};
        repeat (2) scan_frame(f, 1'b0);
        drain("t_err");
        chk("t_err_flag", int'(bus.err_flag), 1);
        chk("t_err_value_held", int'(bus.value), 1);

        // invalid pattern 0x12 on tens digit, then clean pair
        f = '{0, 12, 2, 0};
        scan_frame(f, 1'b0);
        drain("t_bad");
        f = '{0, 5, 2, 0};
        repeat (2) scan_frame(f, 1'b0);
        drain("t_after_bad");
        chk("t_after_bad_value", int'(bus.value), 250);
        chk("t_after_bad_err", int'(bus.err_flag), 0);

        // glitches and anode overlaps
        f = '{4, 3, 2, 1};
        repeat (2) scan_frame(f, 1'b1);
        drain("t_glitch");
        chk("t_glitch_value", int'(bus.value), 1234);

        // randomized frame groups
        for (int g = 0; g < 30; g++) begin
            int reps;
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 80)      f[i] = r % 10;
                else if (r < 88) f[i] = 11;
                else if (r < 94) f[i] = 10;
                else             f[i] = 13;
            end
            reps = $urandom_range(1, 3);
            for (int k = 0; k < reps; k++) scan_frame(f, $urandom_range(0, 1) == 1);
        end
        drain("t_random");

        // timeout then resume with identical frames
        f = '{0, 9, 8, 7};
        repeat (2) scan_frame(f, 1'b0);
        drain("t_pre_timeout");
        repeat (TMO + 20) @(negedge clk);
        chk("t_timeout_active", int'(bus.active), 0);
        chk("t_timeout_value_held", int'(bus.value), m_value);
        chk("t_timeout_err_held", int'(bus.err_flag), m_err);
        m_match = 0;
        m_pub   = 0;
        repeat (2) scan_frame(f, 1'b0);
        drain("t_resume");
        chk("t_resume_active", int'(bus.active), 1);
        chk("t_resume_value", int'(bus.value), 7890);

        // reset in the middle of a frame
        scan_digit(0, 3, 0);
        scan_digit(1, 4, 0);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        model_reset();
        exp_q.delete();
        bad_q.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        bus.an_n  = 4'hF;
        f = '{1, 2, 3, 4};
        repeat (2) scan_frame(f, 1'b0);
        drain("t_post_reset");
        chk("t_post_reset_value", int'(bus.value), 4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
